serial_adder_driver: RTL and testbench

//   Driving end of the bit-serial adder stream. Accepts a parallel operand

---
 rtl/serial_adder_driver_if.sv | 28 ++
 rtl/serial_adder_driver.sv | 100 ++++++++++
 tb/tb_serial_adder_driver.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_driver_if.sv
// Bundle between word-level logic, the serial driver and the bit-serial adder.
// valid/ready: a transfer happens on a posedge where both are high; the source holds data stable while valid is high and not yet taken.
interface serial_adder_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_vld;
  logic             ser_a;
  logic             ser_b;
  logic             ser_last;
  logic             ser_sum;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_ready;

  modport master (
    output in_valid, in_a, in_b, ser_sum, res_ready,
    input  in_ready, ser_vld, ser_a, ser_b, ser_last, res_valid, res_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, ser_sum, res_ready,
    output in_ready, ser_vld, ser_a, ser_b, ser_last, res_valid, res_sum
  );
endinterface

// File: rtl/serial_adder_driver.sv
// Serializes an operand pair LSB-first into a bit-serial adder and gathers the
// returned sum bits into a parallel result.
module serial_adder_driver #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_driver_if.slave bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             in_ready_q;
  logic             ser_vld_q;
  logic             res_valid_q;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Returned sum bits enter from the MSB side so bit 0 ends up LSB after WIDTH shifts.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = bus.ser_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      res_sr      <= '0;
      in_ready_q  <= 1'b1;
      ser_vld_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.in_a;
            b_sr       <= bus.in_b;
            res_sr     <= '0;
            cnt        <= '0;
            state      <= SHIFT;
            in_ready_q <= 1'b0;
            ser_vld_q  <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            cnt         <= '0;
            state       <= DONE;
            ser_vld_q   <= 1'b0;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          ser_vld_q   <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Serial bits are gated by ser_vld so they read 0 outside a word.
  assign bus.in_ready  = in_ready_q;
  assign bus.ser_vld   = ser_vld_q;
  assign bus.ser_a     = ser_vld_q & a_sr[0];
  assign bus.ser_b     = ser_vld_q & b_sr[0];
  assign bus.ser_last  = ser_vld_q & last_bit;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sr;
  assign dbg_state     = state;
endmodule

// File: tb/tb_serial_adder_driver.sv
// Bench for serial_adder_driver: behavioural serial adder, operand/result
// scoreboard, directed scenarios followed by randomized operand traffic.
module tb_serial_adder_driver;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  serial_adder_driver_if #(.WIDTH(W)) bus();

  serial_adder_driver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // bit-serial adder: carry cleared whenever the stream is idle
  logic carry;
  assign bus.ser_sum = bus.ser_a ^ bus.ser_b ^ carry;
  always @(posedge clk or posedge rst) begin
    if (rst) carry <= 1'b0;
    else     carry <= bus.ser_vld ? ((bus.ser_a & bus.ser_b) | (bus.ser_a & carry) | (bus.ser_b & carry)) : 1'b0;
  end

  // result consumer
  bit ready_mode  = 1'b0;
  bit ready_force = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.res_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wa_q[$];
  logic [W-1:0] wb_q[$];
  logic [W-1:0] ca, cb, hold_sum;
  int  cur_acc = 0, prev_acc = 0, idx = 0;
  bit  have_prev = 0, res_seen = 0, hold = 0, gap_chk = 0;

  always @(negedge clk) begin
    if (!gap_chk) have_prev = 0;
    if (rst) begin
      check_eq("rst_ser_vld", bus.ser_vld, 0);
      check_eq("rst_res_valid", bus.res_valid, 0);
      check_eq("rst_in_ready", bus.in_ready, 1);
      check_eq("rst_res_sum", bus.res_sum, 0);
      exp_q.delete(); wa_q.delete(); wb_q.delete();
      idx = 0; hold = 0; res_seen = 0; have_prev = 0;
    end else begin
      if (!bus.ser_vld) check_eq("ser_idle_zero", {bus.ser_a, bus.ser_b, bus.ser_last}, 0);
      if (!bus.ser_vld && !bus.res_valid) check_eq("in_ready_idle", bus.in_ready, 1);
      if (bus.ser_vld) begin
        check_eq("in_ready_shift", bus.in_ready, 0);
        if (wa_q.size() == 0) begin
          check_eq("unexpected_ser_vld", bus.ser_vld, 0);
        end else begin
          ca = wa_q[0];
          cb = wb_q[0];
          check_eq("ser_a", bus.ser_a, ca[idx]);
          check_eq("ser_b", bus.ser_b, cb[idx]);
          check_eq("ser_last", bus.ser_last, (idx == W - 1));
          check_eq("bit_time", cyc - cur_acc, idx);
          idx++;
          if (idx == W) begin
            void'(wa_q.pop_front());
            void'(wb_q.pop_front());
            idx = 0;
          end
        end
      end
      if (bus.res_valid) begin
        check_eq("in_ready_done", bus.in_ready, 0);
        if (!res_seen) begin
          check_eq("res_latency", cyc - cur_acc, W);
          res_seen = 1;
        end
        if (hold) check_eq("res_stable", bus.res_sum, hold_sum);
        hold_sum = bus.res_sum;
        hold     = !bus.res_ready;
        if (bus.res_ready) begin
          if (exp_q.size() == 0) check_eq("unexpected_res", bus.res_valid, 0);
          else                   check_eq("res_sum", bus.res_sum, exp_q.pop_front());
        end
      end else begin
        hold = 0;
      end
      // handshake completes on the coming posedge
      if (bus.in_valid && bus.in_ready) begin
        if (gap_chk && have_prev) check_eq("word_period", cyc + 1 - prev_acc, W + 2);
        cur_acc   = cyc + 1;
        prev_acc  = cur_acc;
        have_prev = 1;
        res_seen  = 0;
        idx       = 0;
        wa_q.push_back(bus.in_a);
        wb_q.push_back(bus.in_b);
        exp_q.push_back(W'((32'(bus.in_a) + 32'(bus.in_b)) % (32'd1 << W)));
      end
    end
  end

  // driver tasks
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !rst) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", bus.in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wa_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_in_ready", bus.in_ready, 1);
    check_eq("reset_ser_vld", bus.ser_vld, 0);
    check_eq("reset_res_valid", bus.res_valid, 0);
    check_eq("reset_res_sum", bus.res_sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic words, carry dropped
    send_op(8'h05, 8'h03);
    drain();
    send_op(8'hFF, 8'h01);
    drain();

    // consumer stalls in DONE while in_valid pulses
    ready_force = 1'b0;
    send_op(8'h21, 8'h42);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 50);
    check_eq("stall_reach_done", bus.res_valid, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      @(negedge clk);
      check_eq("stall_res_valid", bus.res_valid, 1);
      check_eq("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    ready_force  = 1'b1;
    drain();

    // reset on the 4th serial bit
    send_op(8'h5A, 8'h3C);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("midrst_ser_vld", bus.ser_vld, 0);
    check_eq("midrst_res_valid", bus.res_valid, 0);
    check_eq("midrst_in_ready", bus.in_ready, 1);
    check_eq("midrst_res_sum", bus.res_sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_op(8'h12, 8'h34);
    drain();

    // back-to-back words at the minimum period
    gap_chk = 1'b1;
    send_op(8'h10, 8'h20);
    send_op(8'h7F, 8'h01);
    send_op(8'hAA, 8'h55);
    drain();
    gap_chk = 1'b0;

    // in_valid pulsed during SHIFT
    send_op(8'h33, 8'h44);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'hFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    // randomized traffic with a random consumer
    ready_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_op(W'($urandom), W'($urandom));
    end
    ready_force = 1'b1;
    ready_mode  = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
